// File: rtl/pipe_test_pkg.sv
// Shared constants for the PipeIn/PipeOut pattern test endpoints.
// Both sides must agree on the seed, taps and mode encoding.
package pipe_test_pkg;

  localparam logic [31:0] LFSR_SEED      = 32'h0403_0201;
  // Taps 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  localparam logic [31:0] THROTTLE_RESET = 32'hFFFF_FFFF;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_LFSR  = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// Counter/LFSR word source; only the selected generator advances on a write.
// Word is combinational from the registers, so it reflects a mode change at once.
module pipe_pattern_gen
  import pipe_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reseed,
  input  logic        advance,
  input  logic        mode,
  output logic [63:0] word
);

  logic [63:0] r_cnt;
  logic [31:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 64'd1;
      r_lfsr <= LFSR_SEED;
    end else if (reseed) begin
      r_cnt  <= 64'd1;
      r_lfsr <= LFSR_SEED;
    end else if (advance) begin
      if (mode == MODE_LFSR) r_lfsr <= lfsr_next(r_lfsr);
      else                   r_cnt  <= r_cnt + 64'd1;
    end
  end

  assign word = (mode == MODE_LFSR) ? {~r_lfsr, r_lfsr} : r_cnt;

endmodule

// File: rtl/pipe_out_source.sv
// Writes a counter or LFSR stream into the PipeOut FIFO, gated by a rotating throttle
// mask and FIFO headroom; one registered write per eligible cycle.
module pipe_out_source
  import pipe_test_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int COUNT_W    = 9,
  parameter int FIFO_DEPTH = 512,
  parameter int HEADROOM   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pipe_out_start,
  input  logic [COUNT_W-1:0] pipe_out_count,
  output logic               pipe_out_write,
  output logic [DATA_W-1:0]  pipe_out_data,
  input  logic               throttle_set,
  input  logic [31:0]        throttle_val,
  input  logic               mode,
  output logic [31:0]        words_written
);

  localparam logic [COUNT_W-1:0] FULL_MARK = COUNT_W'(FIFO_DEPTH - HEADROOM);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_throttle;
  logic        w_eligible;
  logic [63:0] w_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_eligible  = 1'b0;
    if (pipe_out_start) begin
      w_state_nxt = RUN;
    end else if (r_state == RUN) begin
      w_eligible = r_throttle[0] && (pipe_out_count < FULL_MARK);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_throttle <= THROTTLE_RESET;
    else if (throttle_set) r_throttle <= throttle_val;
    else                   r_throttle <= {r_throttle[30:0], r_throttle[31]};
  end

  pipe_pattern_gen u_gen (
    .clk     (clk),
    .reset   (reset),
    .reseed  (pipe_out_start),
    .advance (w_eligible),
    .mode    (mode),
    .word    (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_out_write <= 1'b0;
      pipe_out_data  <= '0;
      words_written  <= 32'd0;
    end else begin
      pipe_out_write <= w_eligible;
      if (w_eligible) pipe_out_data <= w_word;
      if (pipe_out_start)
        words_written <= 32'd0;
      else if (w_eligible && (words_written != 32'hFFFF_FFFF))
        words_written <= words_written + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_out_source.sv
// Randomized bench for pipe_out_source with a cycle-level reference model and
// directed literal checks on the counter, LFSR, throttle, stall, restart and reset behaviour.
module tb_pipe_out_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_out_start = 1'b0;
  logic [8:0]  pipe_out_count = 9'd0;
  logic        pipe_out_write;
  logic [63:0] pipe_out_data;
  logic        throttle_set = 1'b0;
  logic [31:0] throttle_val = 32'd0;
  logic        mode = 1'b0;
  logic [31:0] words_written;

  pipe_out_source dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_out_start (pipe_out_start),
    .pipe_out_count (pipe_out_count),
    .pipe_out_write (pipe_out_write),
    .pipe_out_data  (pipe_out_data),
    .throttle_set   (throttle_set),
    .throttle_val   (throttle_val),
    .mode           (mode),
    .words_written  (words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run flag, two pattern sources, throttle as (pattern, cycles since load)
  bit          m_run   = 1'b0;
  logic [63:0] m_cnt   = 64'd1;
  logic [31:0] m_lfsr  = 32'h0403_0201;
  logic [31:0] m_tval  = 32'hFFFF_FFFF;
  int          m_phase = 0;
  bit          exp_wr  = 1'b0;
  logic [63:0] exp_data = 64'd0;
  logic [31:0] exp_ww  = 32'd0;

  function automatic logic [31:0] step_lfsr(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always @(posedge clk or posedge reset) begin
    bit thr_bit;
    bit elig;
    if (reset) begin
      m_run = 1'b0; m_cnt = 64'd1; m_lfsr = 32'h0403_0201;
      m_tval = 32'hFFFF_FFFF; m_phase = 0;
      exp_wr = 1'b0; exp_data = 64'd0; exp_ww = 32'd0;
      #1;
      check("reset_write", {63'd0, pipe_out_write}, 64'd0);
      check("reset_data", pipe_out_data, 64'd0);
      check("reset_words", {32'd0, words_written}, 64'd0);
    end else begin
      // After k rotations left, bit 0 holds original bit (32-k) mod 32
      thr_bit = m_tval[(32 - m_phase) % 32];
      elig    = m_run && thr_bit && (pipe_out_count < 9'd508) && !pipe_out_start;
      exp_wr  = elig;
      if (pipe_out_start) begin
        m_run = 1'b1; m_cnt = 64'd1; m_lfsr = 32'h0403_0201; exp_ww = 32'd0;
      end else if (elig) begin
        if (mode) begin
          exp_data = {~m_lfsr, m_lfsr};
          m_lfsr   = step_lfsr(m_lfsr);
        end else begin
          exp_data = m_cnt;
          m_cnt    = m_cnt + 64'd1;
        end
        if (exp_ww != 32'hFFFF_FFFF) exp_ww = exp_ww + 32'd1;
      end
      if (throttle_set) begin
        m_tval = throttle_val; m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % 32;
      end
      #1;
      if (!reset) begin
        check("model_write", {63'd0, pipe_out_write}, {63'd0, exp_wr});
        check("model_data", pipe_out_data, exp_data);
        check("model_words", {32'd0, words_written}, {32'd0, exp_ww});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    tick(); pipe_out_start = 1'b1;
    tick(); pipe_out_start = 1'b0;
  endtask

  initial begin
    int          nwr;
    logic [63:0] last;

    repeat (3) tick();
    check("reset_hold_write", {63'd0, pipe_out_write}, 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_no_write", {63'd0, pipe_out_write}, 64'd0);

    // Counter stream: first write two edges after the start pulse
    pulse_start();
    check("start_no_write", {63'd0, pipe_out_write}, 64'd0);
    tick(); check("cnt_w1", pipe_out_data, 64'd1);
    check("cnt_w1_strobe", {63'd0, pipe_out_write}, 64'd1);
    tick(); check("cnt_w2", pipe_out_data, 64'd2);
    tick(); check("cnt_w3", pipe_out_data, 64'd3);
    check("cnt_words3", {32'd0, words_written}, 64'd3);
    repeat (10) tick();

    // LFSR stream
    mode = 1'b1;
    pulse_start();
    tick(); check("lfsr_w1", pipe_out_data, 64'hFBFC_FDFE_0403_0201);
    tick(); check("lfsr_w2", pipe_out_data, 64'hF7F9_FBFC_0806_0403);
    repeat (5) tick();

    // Throttle 0101...: half the cycles write
    mode = 1'b0;
    throttle_val = 32'h5555_5555; throttle_set = 1'b1;
    tick(); throttle_set = 1'b0; pipe_out_start = 1'b1;
    tick(); pipe_out_start = 1'b0;
    tick();
    nwr = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (pipe_out_write) nwr++;
    end
    check("throttle_16_of_32", 64'(nwr), 64'd16);
    throttle_val = 32'hFFFF_FFFF; throttle_set = 1'b1;
    tick(); throttle_set = 1'b0;
    repeat (3) tick();

    // Backpressure at the headroom mark
    last = pipe_out_data;
    pipe_out_count = 9'd508;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pipe_out_write) nwr++;
    end
    check("stall_no_writes", 64'(nwr), 64'd0);
    last = pipe_out_data;
    pipe_out_count = 9'd507;
    tick();
    check("resume_strobe", {63'd0, pipe_out_write}, 64'd1);
    check("resume_next_word", pipe_out_data, last + 64'd1);
    repeat (3) tick();

    // Restart while running
    pipe_out_start = 1'b1;
    tick(); pipe_out_start = 1'b0;
    check("restart_no_write", {63'd0, pipe_out_write}, 64'd0);
    check("restart_words0", {32'd0, words_written}, 64'd0);
    tick(); check("restart_word1", pipe_out_data, 64'd1);
    repeat (3) tick();

    // Counter wrap
    pipe_out_count = 9'd508;
    tick();
    force dut.u_gen.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.u_gen.r_cnt;
    tick();
    pipe_out_count = 9'd0;
    tick(); check("wrap_max", pipe_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); check("wrap_zero", pipe_out_data, 64'd0);
    tick(); check("wrap_one", pipe_out_data, 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      pipe_out_start = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 2) pipe_out_count = 9'($urandom_range(505, 511));
      else                          pipe_out_count = 9'($urandom_range(0, 504));
      if ($urandom_range(0, 49) == 0) begin
        throttle_set = 1'b1;
        throttle_val = $urandom | $urandom;
      end else begin
        throttle_set = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) mode = ~mode;
    end
    tick();
    pipe_out_start = 1'b0; throttle_set = 1'b0;
    throttle_val = 32'hFFFF_FFFF; throttle_set = 1'b1;
    tick(); throttle_set = 1'b0;
    pipe_out_count = 9'd0; mode = 1'b0;

    // Asynchronous reset mid-transfer
    pulse_start();
    repeat (5) tick();
    check("pre_reset_writing", {63'd0, pipe_out_write}, 64'd1);
    #2 reset = 1'b1;
    #1 check("async_reset_write", {63'd0, pipe_out_write}, 64'd0);
    check("async_reset_words", {32'd0, words_written}, 64'd0);
    tick(); reset = 1'b0;
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pipe_out_write) nwr++;
    end
    check("post_reset_idle", 64'(nwr), 64'd0);
    pulse_start();
    tick(); check("post_reset_word1", pipe_out_data, 64'd1);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
